nram_write_sequencer: RTL and testbench
=======================================

// Module: nram_write_sequencer
// PURPOSE
//  Upstream feeder for the NRAM lane register file. Accepts a valid/ready byte stream and buffers
//  it in a small FIFO. Each byte is issued as one single-cycle write strobe on io_ENbus with the
//  byte on io_Dbus. Target lanes are chosen round-robin (lane 0,1,0,...) or all at once in
//  broadcast mode. io_Dbus/io_ENbus connect directly to the NRAM ports of the same names.
// PARAMETERS
//  DATA_W      8  width of stream bytes and io_Dbus
//  LANES       2  number of NRAM lanes = width of io_ENbus (>=2)
//  FIFO_DEPTH  4  input buffer entries; power of two, >=2
//  GAP         0  idle cycles forced after every write strobe (0..15)
// PORTS
//  clk          in   1                      rising-edge clock
//  reset        in   1                      asynchronous, active-low (0 = reset)
//  io_in_valid  in   1                      stream byte valid
//  io_in_ready  out  1                      sequencer can accept a byte
//  io_in_bits   in   DATA_W                 stream byte
//  io_bcast     in   1                      1 = strobe all lanes; sampled when a write issues
//  io_Dbus      out  DATA_W                 write data to NRAM
//  io_ENbus     out  LANES                  write enables to NRAM (one-hot or all-ones)
//  io_busy      out  1                      FIFO non-empty or FSM not IDLE
//  io_wr_count  out  16                     total write strobes issued, wraps
// BEHAVIOUR
//  - Reset (reset==0, async): FIFO empty, rd/wr pointers 0, lane pointer 0, FSM IDLE, gap
//    counter 0, io_Dbus=0, io_ENbus=0, io_busy=0, io_wr_count=0, io_in_ready=0. io_in_ready
//    rises on the first clk edge after reset deasserts.
//  - Handshake: a byte is accepted on a clk edge with io_in_valid && io_in_ready.
//    io_in_ready = !full (registered occupancy). When full, no push occurs even if a pop happens
//    in the same cycle; ready rises the following cycle.
//  - Latency: a byte accepted at edge t into an empty FIFO drives io_ENbus at the earliest in the
//    cycle after edge t+1. There is no FIFO bypass.
//  - FSM (registered outputs):
//      IDLE: io_ENbus=0. If FIFO non-empty, pop head and go to WRITE.
//      WRITE: exactly one cycle. io_Dbus=popped byte. io_ENbus = 1<<lane_ptr, or all-ones if
//        io_bcast was 1 at issue. io_wr_count increments by 1, even for broadcast.
//        Round-robin only: lane_ptr advances, wrapping LANES-1 -> 0. Broadcast: lane_ptr unchanged.
//        Next state: GAP if GAP>0. Otherwise WRITE again (back-to-back) if FIFO non-empty,
//        else IDLE.
//      GAP: io_ENbus=0 for exactly GAP cycles, then behave as IDLE.
//  - io_Dbus holds the last written byte when io_ENbus=0. It is never X after reset.
//  - Simultaneous push and pop: both take effect in the same cycle and occupancy is unchanged.
//  - Pointers are log2(FIFO_DEPTH) bits plus a wrap bit. full = MSBs differ and LSBs equal.
//  - Reset mid-operation discards all buffered bytes. An asserted strobe drops to 0 immediately
//    (asynchronously).
//  - io_busy = (occupancy != 0) || (state != IDLE).
// CONFIGURATION
//  - NRAM_SEQ_FLUSH_EN defined: adds input port io_flush (1 bit, after io_bcast). On a clk edge
//    with io_flush=1:
//      - FIFO is emptied and lane_ptr returns to 0.
//      - FSM goes to IDLE; a WRITE in progress in that cycle still completes its single strobe.
//      - Any push in the same cycle is dropped.
//      - io_wr_count is not cleared.
//  - NRAM_SEQ_FLUSH_EN undefined: no io_flush port. Buffer contents are cleared only by reset.
// TESTING
//  1. Reset released, push 0xA1,0xB2,0xC3 back-to-back (bcast=0, GAP=0): ENbus 01,10,01 on three
//     consecutive cycles with Dbus A1,B2,C3; io_wr_count=3; NRAM io_Qbus_0=C3, io_Qbus_1=B2.
//  2. Push 6 bytes while holding the output stalled by GAP=3: io_in_ready drops after the 4th
//     stored byte and recovers after the next pop. No byte is lost or duplicated; order holds.
//  3. io_bcast=1 with byte 0x5A: ENbus=11 for one cycle, Dbus=5A, lane_ptr unchanged. The next
//     round-robin write goes to the same lane as before.
//  4. Drop reset to 0 while WRITE is active with 3 bytes buffered: ENbus=0 at once, busy=0,
//     wr_count=0. After release, the next pushed byte goes to lane 0.
//  5. GAP=2, push 2 bytes: strobes are exactly 3 cycles apart with ENbus=0 between them.
//  6. (NRAM_SEQ_FLUSH_EN) Buffer 3 bytes, pulse io_flush: at most one further strobe, then idle.
//     busy=0 two cycles later; the next byte goes to lane 0.

Source files
------------

// File: rtl/nram_write_sequencer.sv
`timescale 1ns/1ps
// nram_write_sequencer
// Buffers a valid/ready byte stream in a small FIFO and replays each byte as a
// single-cycle write strobe towards the NRAM lanes, round-robin or broadcast.
// Optional feature: define NRAM_SEQ_FLUSH_EN to add the io_flush input, which
// empties the buffer and returns the lane pointer to lane 0.
module nram_write_sequencer #(
  parameter int DATA_W     = 8,
  parameter int LANES      = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP        = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_in_valid,
  output logic              io_in_ready,
  input  logic [DATA_W-1:0] io_in_bits,
  input  logic              io_bcast,
`ifdef NRAM_SEQ_FLUSH_EN
  input  logic              io_flush,
`endif
  output logic [DATA_W-1:0] io_Dbus,
  output logic [LANES-1:0]  io_ENbus,
  output logic              io_busy,
  output logic [15:0]       io_wr_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(LANES);
  localparam logic [3:0]    GAP_CYC   = 4'(GAP);
  localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_GAP} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [AW:0]       r_wr_ptr;
  logic [AW:0]       r_rd_ptr;
  logic [AW:0]       w_wr_ptr_nxt;
  logic [AW:0]       w_rd_ptr_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [LW-1:0]     r_lane;
  logic [3:0]        r_gap_cnt;
  logic [3:0]        w_gap_nxt;
  logic              r_ready;
  logic [DATA_W-1:0] r_dbus;
  logic [LANES-1:0]  r_enbus;
  logic [15:0]       r_wr_count;
  logic              w_flush;
  logic              w_empty;
  logic              w_full;
  logic              w_full_nxt;
  logic              w_push;
  logic              w_pop;
  logic [LANES-1:0]  w_en_mask;

`ifdef NRAM_SEQ_FLUSH_EN
  assign w_flush = io_flush;
`else
  assign w_flush = 1'b0;
`endif

  // Occupancy flags come from the wrap-bit pointer pair.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // A push needs a ready slot; a flush in the same cycle wins and drops it.
  assign w_push    = io_in_valid && r_ready && !w_full && !w_flush;
  assign w_en_mask = io_bcast ? {LANES{1'b1}} : (LANES'(1) << r_lane);

  assign io_in_ready = r_ready;
  assign io_Dbus     = r_dbus;
  assign io_ENbus    = r_enbus;
  assign io_wr_count = r_wr_count;
  assign io_busy     = !w_empty || (r_state != S_IDLE);

  // Next-state logic: issue decision for IDLE, back-to-back WRITE and gap expiry.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_gap_nxt   = r_gap_cnt;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (GAP_CYC != 4'd0) begin
          w_state_nxt = S_GAP;
          w_gap_nxt   = GAP_CYC;
        end else if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_WRITE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_GAP: begin
        if (r_gap_cnt > 4'd1) begin
          w_gap_nxt = r_gap_cnt - 4'd1;
        end else begin
          // Last gap cycle makes the IDLE decision so strobes land GAP+1 apart.
          w_gap_nxt = 4'd0;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WRITE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_flush) begin
      w_pop       = 1'b0;
      w_state_nxt = S_IDLE;
      w_gap_nxt   = 4'd0;
    end
  end

  // Next pointer values; ready is derived from them so it reflects registered occupancy.
  always_comb begin
    w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
    if (w_flush) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
    end
    w_full_nxt = (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                 (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
  end

  // FIFO storage; contents are only observable through popped entries.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= io_in_bits;
  end

  // Control state and registered NRAM-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_lane     <= '0;
      r_gap_cnt  <= 4'd0;
      r_ready    <= 1'b0;
      r_dbus     <= '0;
      r_enbus    <= '0;
      r_wr_count <= 16'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_wr_ptr  <= w_wr_ptr_nxt;
      r_rd_ptr  <= w_rd_ptr_nxt;
      r_gap_cnt <= w_gap_nxt;
      r_ready   <= !w_full_nxt;
      if (w_pop) begin
        r_dbus     <= r_mem[r_rd_ptr[AW-1:0]];
        r_enbus    <= w_en_mask;
        r_wr_count <= r_wr_count + 16'd1;
        if (!io_bcast) r_lane <= (r_lane == LANE_LAST) ? '0 : r_lane + LW'(1);
      end else begin
        r_enbus <= '0;
      end
      if (w_flush) r_lane <= '0;
    end
  end

endmodule

// File: tb/tb_nram_write_sequencer.sv
`timescale 1ns/1ps
// Bench for nram_write_sequencer: three instances (GAP=0, 2, 3) driven with
// directed byte sequences; a strobe monitor and a two-lane NRAM model record
// what reaches the NRAM side.
module tb_nram_write_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        vld  [3];
  logic [7:0]  bits [3];
  logic        bc   [3];
  logic        rdy  [3];
  logic [7:0]  db   [3];
  logic [1:0]  en   [3];
  logic        busy [3];
  logic [15:0] wcnt [3];
  logic        saw_full [3];
`ifdef NRAM_SEQ_FLUSH_EN
  logic        fl   [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    nram_write_sequencer #(
      .DATA_W(8), .LANES(2), .FIFO_DEPTH(4),
      .GAP((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk(clk),
      .reset(rst_n),
      .io_in_valid(vld[g]),
      .io_in_ready(rdy[g]),
      .io_in_bits(bits[g]),
      .io_bcast(bc[g]),
`ifdef NRAM_SEQ_FLUSH_EN
      .io_flush(fl[g]),
`endif
      .io_Dbus(db[g]),
      .io_ENbus(en[g]),
      .io_busy(busy[g]),
      .io_wr_count(wcnt[g])
    );
  end

  typedef struct packed {
    logic [1:0]  inst;
    logic [15:0] cyc;
    logic [1:0]  en;
    logic [7:0]  d;
  } strobe_t;

  strobe_t     sq[$];
  int unsigned cyc_n = 0;
  logic [7:0]  nq0 [3];
  logic [7:0]  nq1 [3];
  int          n_chk = 0;
  int          n_bad = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Strobe monitor and NRAM lane model, sampled on the inactive edge.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (en[g] != 2'b00) begin
        sq.push_back('{inst: 2'(g), cyc: 16'(cyc_n), en: en[g], d: db[g]});
        if (en[g][0]) nq0[g] <= db[g];
        if (en[g][1]) nq1[g] <= db[g];
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Holds valid until the byte is taken; returns 1 ns after the accepting edge.
  task automatic push_byte(input int g, input logic [7:0] b);
    logic acc;
    int   n;
    vld[g]  = 1'b1;
    bits[g] = b;
    n = 0;
    do begin
      acc = rdy[g];
      if (!acc) saw_full[g] = 1'b1;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 40);
    if (!acc) check_val("push_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    for (int g = 0; g < 3; g++) begin
      vld[g] = 1'b0; bits[g] = 8'h00; bc[g] = 1'b0; saw_full[g] = 1'b0;
`ifdef NRAM_SEQ_FLUSH_EN
      fl[g] = 1'b0;
`endif
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check_val("rst_ready", rdy[0], 0);
    check_val("rst_en", en[0], 0);
    check_val("rst_dbus", db[0], 0);
    check_val("rst_busy", busy[0], 0);
    check_val("rst_wcnt", wcnt[0], 0);
    rst_n = 1'b1;
    #2;
    check_val("ready_before_edge", rdy[0], 0);
    @(posedge clk); #1;
    check_val("ready_after_edge", rdy[0], 1);

    // Round-robin, back-to-back, GAP=0
    sq.delete();
    push_byte(0, 8'hA1); push_byte(0, 8'hB2); push_byte(0, 8'hC3);
    vld[0] = 1'b0;
    wait_cycles(6);
    check_val("t1_count", sq.size(), 3);
    check_val("t1_en0", sq[0].en, 2'b01); check_val("t1_d0", sq[0].d, 8'hA1);
    check_val("t1_en1", sq[1].en, 2'b10); check_val("t1_d1", sq[1].d, 8'hB2);
    check_val("t1_en2", sq[2].en, 2'b01); check_val("t1_d2", sq[2].d, 8'hC3);
    check_val("t1_spacing01", sq[1].cyc - sq[0].cyc, 1);
    check_val("t1_spacing12", sq[2].cyc - sq[1].cyc, 1);
    check_val("t1_wcnt", wcnt[0], 3);
    check_val("t1_qbus0", nq0[0], 8'hC3);
    check_val("t1_qbus1", nq1[0], 8'hB2);
    check_val("t1_idle_en", en[0], 0);
    check_val("t1_dbus_hold", db[0], 8'hC3);
    check_val("t1_idle_busy", busy[0], 0);

    // Broadcast leaves the lane pointer on lane 1
    sq.delete();
    bc[0] = 1'b1;
    push_byte(0, 8'h5A);
    vld[0] = 1'b0;
    wait_cycles(2);
    bc[0] = 1'b0;
    wait_cycles(3);
    push_byte(0, 8'h77);
    vld[0] = 1'b0;
    wait_cycles(5);
    check_val("t3_count", sq.size(), 2);
    check_val("t3_bc_en", sq[0].en, 2'b11);
    check_val("t3_bc_d", sq[0].d, 8'h5A);
    check_val("t3_next_en", sq[1].en, 2'b10);
    check_val("t3_next_d", sq[1].d, 8'h77);
    check_val("t3_wcnt", wcnt[0], 5);
    check_val("t3_qbus0", nq0[0], 8'h5A);

    // GAP=2: strobes three cycles apart
    sq.delete();
    push_byte(1, 8'h11); push_byte(1, 8'h22);
    vld[1] = 1'b0;
    wait_cycles(10);
    check_val("t5_count", sq.size(), 2);
    check_val("t5_en0", sq[0].en, 2'b01); check_val("t5_d0", sq[0].d, 8'h11);
    check_val("t5_en1", sq[1].en, 2'b10); check_val("t5_d1", sq[1].d, 8'h22);
    check_val("t5_spacing", sq[1].cyc - sq[0].cyc, 3);
    check_val("t5_wcnt", wcnt[1], 2);

    // GAP=3: six bytes overrun the four-entry buffer
    sq.delete();
    for (int i = 1; i <= 6; i++) push_byte(2, 8'(i));
    vld[2] = 1'b0;
    wait_cycles(40);
    check_val("t2_backpressure", saw_full[2], 1);
    check_val("t2_count", sq.size(), 6);
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("t2_d%0d", i), sq[i].d, 32'(i + 1));
      check_val($sformatf("t2_en%0d", i), sq[i].en, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (i > 0) check_val($sformatf("t2_spacing%0d", i), sq[i].cyc - sq[i-1].cyc, 4);
    end
    check_val("t2_wcnt", wcnt[2], 6);
    check_val("t2_ready", rdy[2], 1);

    // Reset during a WRITE with three bytes buffered
    sq.delete();
    push_byte(2, 8'hD1); push_byte(2, 8'hD2); push_byte(2, 8'hD3);
    push_byte(2, 8'hD4); push_byte(2, 8'hD5);
    vld[2] = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (en[2] == 2'b00 && n < 20);
    check_val("t4_mid_en", en[2], 2'b10);
    check_val("t4_mid_d", db[2], 8'hD2);
    check_val("t4_mid_wcnt", wcnt[2], 8);
    rst_n = 1'b0;
    #1;
    check_val("t4_rst_en", en[2], 0);
    check_val("t4_rst_busy", busy[2], 0);
    check_val("t4_rst_wcnt", wcnt[2], 0);
    check_val("t4_rst_dbus", db[2], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sq.delete();
    push_byte(2, 8'h99);
    vld[2] = 1'b0;
    wait_cycles(8);
    check_val("t4_after_count", sq.size(), 1);
    check_val("t4_after_en", sq[0].en, 2'b01);
    check_val("t4_after_d", sq[0].d, 8'h99);
    check_val("t4_after_wcnt", wcnt[2], 1);
    sq.delete();
    push_byte(2, 8'h98);
    vld[2] = 1'b0;
    wait_cycles(8);
    check_val("t4_second_en", sq[0].en, 2'b10);
    check_val("t4_second_wcnt", wcnt[2], 2);

`ifdef NRAM_SEQ_FLUSH_EN
    // Flush with three bytes buffered, lane pointer on lane 1
    sq.delete();
    push_byte(2, 8'hF1); push_byte(2, 8'hF2); push_byte(2, 8'hF3); push_byte(2, 8'hF4);
    vld[2] = 1'b0;
    fl[2] = 1'b1;
    @(posedge clk); #1;
    fl[2] = 1'b0;
    check_val("t6_busy_1", busy[2], 0);
    wait_cycles(1);
    check_val("t6_busy_2", busy[2], 0);
    check_val("t6_ready", rdy[2], 1);
    wait_cycles(8);
    check_val("t6_strobes", sq.size(), 1);
    check_val("t6_first_d", sq[0].d, 8'hF1);
    check_val("t6_wcnt_kept", wcnt[2], 3);
    sq.delete();
    push_byte(2, 8'h3C);
    vld[2] = 1'b0;
    wait_cycles(8);
    check_val("t6_next_en", sq[0].en, 2'b01);
    check_val("t6_next_d", sq[0].d, 8'h3C);
    check_val("t6_next_wcnt", wcnt[2], 4);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
